branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the fetch stage of the 5-stage RV32I pipeline. It replaces static "predict not-taken, resolve in EX, flush" with a direct-mapped branch target buffer (BTB) plus a table of saturating direction counters. The fetch stage looks it up with `PC_F`. The execute stage updates it with resolved outcomes and receives a mispredict/recovery signal that drives the hazard unit's flush. Table depth, counter width and datapath width are parameters.

## Interface
- `WIDTH`, 32: address/data width.
- `ENTRIES`, 64: table entries; power of two, ≥ 2. `IDX = log2(ENTRIES)`.
- `CTR_BITS`, 2: direction counter width, ≥ 1.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `PC_F`  in  WIDTH: fetch PC for lookup.
- `pred_taken_F`  out  1: predict taken at `PC_F`.
- `pred_target_F`  out  WIDTH: predicted target; equals `PC_F + 4` when `pred_taken_F=0`.
- `update_en_E`  in  1: a resolved branch or jump is in EX this cycle (not flushed).
- `PC_E`  in  WIDTH: PC of the resolved instruction.
- `taken_E`  in  1: actual direction.
- `target_E`  in  WIDTH: actual taken target.
- `pred_taken_E`, `pred_target_E`  in  1/WIDTH: prediction carried down the pipeline with the instruction.
- `mispredict_E`  out  1: recovery required; drives flush.
- `recover_PC_E`  out  WIDTH: `target_E` if `taken_E`, else `PC_E + 4`.
- `branch_count`, `mispredict_count`  out  32 each: saturating performance counters.

## Operation
- Index = `PC[IDX+1:2]`; tag = `PC[WIDTH-1:IDX+2]`. Each entry holds `valid`, tag, target and counter.
- Lookup is combinational with zero latency. Hit = `valid && tag match`. `pred_taken_F = hit && ctr[CTR_BITS-1]`.
- Mispredict: `mispredict_E = update_en_E && ((taken_E != pred_taken_E) || (taken_E && target_E != pred_target_E))`. It is 0 when `update_en_E=0`.
- Update on an edge with `update_en_E=1`:
  - Hit, taken: counter saturating +1; target overwritten with `target_E`.
  - Hit, not taken: counter saturating −1; target unchanged.
  - Miss, taken: allocate. Write `valid=1`, tag, `target_E`, and counter set to weakly taken (`2^(CTR_BITS-1)`).
  - Miss, not taken: no change.
- Counter limits: the saturating maximum is `2^CTR_BITS − 1` and the minimum is 0. With `CTR_BITS=1`, the counter is last-outcome.
- Performance counters:
  - `branch_count` +1 per `update_en_E`.
  - `mispredict_count` +1 per `mispredict_E`.
  - Both hold at `32'hFFFF_FFFF`.

## Timing
- Reset (synchronous, rising edge with `rst=1`):
  - All `valid` cleared; all counters set to weakly not-taken (`2^(CTR_BITS-1) − 1`); perf counters set to 0.
  - Outputs in the cycle after reset: `pred_taken_F=0`, `pred_target_F=PC_F+4`; `mispredict_E` and `recover_PC_E` are purely combinational from their inputs.
- Reset has priority over a simultaneous update; the update is lost.
- Update latency: state written at the edge is visible to lookup in the next cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update entry. There is no bypass.
- Aliasing: a different tag at the same index misses. It does not use the aliased counter.
- `mispredict_E` and `recover_PC_E` are combinational in the same cycle as EX. The flush and PC redirect take effect at the next edge.
- Stall does not affect this block. The fetch stage holds `PC_F`, so the lookup output stays stable.

## Structure
- Package `bp_pkg`:
  - Function `ctr_next(ctr, taken)` for saturating update.
  - Function `ctr_init_weak(taken)`.
  - Perf-counter width localparam (32).
- Sub-module `bp_table`: storage arrays, reset clear, single write port and asynchronous read port.
- `branch_predictor`: index/tag split, hit logic, allocation policy, mispredict/recovery and perf counters.

## Test plan
All scenarios use defaults (`ENTRIES=64`, `CTR_BITS=2`).
- Reset, then `PC_F=0x100` → `pred_taken_F=0`, `pred_target_F=0x104`; both perf counters 0.
- Update `PC_E=0x100`, taken, `target_E=0x80`, `pred_taken_E=0` → `mispredict_E=1`, `recover_PC_E=0x80`. Next cycle, lookup `0x100` gives taken, `0x80`; `mispredict_count=1`.
- Three more taken updates at `0x100`, then two not-taken → counter path 2→3→3→3→2→1. Prediction stays taken after the first not-taken and goes not-taken after the second.
- With `0x100` allocated, look up `0x200` (same index, different tag) → miss, `pred_taken_F=0`. A not-taken update at `0x200` leaves entry `0x100` unchanged.
- Correct prediction (taken, `0x80`, predicted taken, `0x80`) → `mispredict_E=0`. Same direction but `target_E=0x90` → `mispredict_E=1`, `recover_PC_E=0x90`.
- Assert `rst` in the same cycle as a taken update at `0x100` → entry not allocated; the next lookup misses.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and saturating-counter helpers for the branch predictor
package bp_pkg;

  localparam int PERF_W    = 32;
  localparam int CTR_MAX_W = 8;

  function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                    input logic                 taken,
                                                    input int unsigned          bits);
    logic [CTR_MAX_W-1:0] max_v;
    max_v = (CTR_MAX_W'(1) << bits) - CTR_MAX_W'(1);
    if (taken) begin
      return (ctr == max_v) ? ctr : ctr + CTR_MAX_W'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_init_weak(input logic        taken,
                                                         input int unsigned bits);
    logic [CTR_MAX_W-1:0] half;
    half = CTR_MAX_W'(1) << (bits - 1);
    return taken ? half : half - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, execute update and perf-counter signals
interface branch_predictor_if
  import bp_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]  PC_F;
  logic              pred_taken_F;
  logic [WIDTH-1:0]  pred_target_F;
  logic              update_en_E;
  logic [WIDTH-1:0]  PC_E;
  logic              taken_E;
  logic [WIDTH-1:0]  target_E;
  logic              pred_taken_E;
  logic [WIDTH-1:0]  pred_target_E;
  logic              mispredict_E;
  logic [WIDTH-1:0]  recover_PC_E;
  logic [PERF_W-1:0] branch_count;
  logic [PERF_W-1:0] mispredict_count;

  modport master (
    output PC_F, update_en_E, PC_E, taken_E, target_E, pred_taken_E, pred_target_E,
    input  pred_taken_F, pred_target_F, mispredict_E, recover_PC_E,
           branch_count, mispredict_count
  );

  modport slave (
    input  PC_F, update_en_E, PC_E, taken_E, target_E, pred_taken_E, pred_target_E,
    output pred_taken_F, pred_target_F, mispredict_E, recover_PC_E,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/bp_table.sv
// rtl/bp_table.sv - BTB/counter storage with one write port and two asynchronous read ports
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int IDX      = 6,
  parameter int TAG_W    = 24,
  parameter int WIDTH    = 32,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX-1:0]      waddr,
  input  logic [TAG_W-1:0]    wtag,
  input  logic [WIDTH-1:0]    wtarget,
  input  logic [CTR_BITS-1:0] wctr,
  input  logic [IDX-1:0]      ra_addr,
  output logic                ra_valid,
  output logic [TAG_W-1:0]    ra_tag,
  output logic [WIDTH-1:0]    ra_target,
  output logic [CTR_BITS-1:0] ra_ctr,
  input  logic [IDX-1:0]      rb_addr,
  output logic                rb_valid,
  output logic [TAG_W-1:0]    rb_tag,
  output logic [WIDTH-1:0]    rb_target,
  output logic [CTR_BITS-1:0] rb_ctr
);
  localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(ctr_init_weak(1'b0, CTR_BITS));

  logic [ENTRIES-1:0]  valid_mem;
  logic [TAG_W-1:0]    tag_mem    [ENTRIES];
  logic [WIDTH-1:0]    target_mem [ENTRIES];
  logic [CTR_BITS-1:0] ctr_mem    [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_mem <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i] <= CTR_RESET;
      end
    end else if (we) begin
      valid_mem[waddr] <= 1'b1;
      ctr_mem[waddr]   <= wctr;
    end
  end

  // Tag/target need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_mem[waddr]    <= wtag;
      target_mem[waddr] <= wtarget;
    end
  end

  assign ra_valid  = valid_mem[ra_addr];
  assign ra_tag    = tag_mem[ra_addr];
  assign ra_target = target_mem[ra_addr];
  assign ra_ctr    = ctr_mem[ra_addr];
  assign rb_valid  = valid_mem[rb_addr];
  assign rb_tag    = tag_mem[rb_addr];
  assign rb_target = target_mem[rb_addr];
  assign rb_ctr    = ctr_mem[rb_addr];
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus saturating direction counters with EX-stage recovery
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2
) (
  input logic                clk,
  input logic                rst,
  branch_predictor_if.slave  bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic [IDX-1:0]      idx_f, idx_e;
  logic [TAG_W-1:0]    tag_f, tag_e;
  logic                f_valid, e_valid, hit_f, hit_e;
  logic [TAG_W-1:0]    f_tag, e_tag;
  logic [WIDTH-1:0]    f_target, e_target, wtarget;
  logic [CTR_BITS-1:0] f_ctr, e_ctr, wctr;
  logic                we;
  logic [PERF_W-1:0]   branch_q, misp_q;
  logic                unused_bits;

  assign idx_f = bus.PC_F[IDX+1:2];
  assign tag_f = bus.PC_F[WIDTH-1:IDX+2];
  assign idx_e = bus.PC_E[IDX+1:2];
  assign tag_e = bus.PC_E[WIDTH-1:IDX+2];

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX     (IDX),
    .TAG_W   (TAG_W),
    .WIDTH   (WIDTH),
    .CTR_BITS(CTR_BITS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (idx_e),
    .wtag     (tag_e),
    .wtarget  (wtarget),
    .wctr     (wctr),
    .ra_addr  (idx_f),
    .ra_valid (f_valid),
    .ra_tag   (f_tag),
    .ra_target(f_target),
    .ra_ctr   (f_ctr),
    .rb_addr  (idx_e),
    .rb_valid (e_valid),
    .rb_tag   (e_tag),
    .rb_target(e_target),
    .rb_ctr   (e_ctr)
  );

  assign hit_f             = f_valid && (f_tag == tag_f);
  assign hit_e             = e_valid && (e_tag == tag_e);
  assign bus.pred_taken_F  = hit_f && f_ctr[CTR_BITS-1];
  assign bus.pred_target_F = bus.pred_taken_F ? f_target : bus.PC_F + WIDTH'(4);

  // A not-taken miss never allocates, so aliased entries survive it.
  always_comb begin
    we      = bus.update_en_E && (hit_e || bus.taken_E);
    wtarget = (hit_e && !bus.taken_E) ? e_target : bus.target_E;
    wctr    = CTR_BITS'(ctr_init_weak(1'b1, CTR_BITS));
    if (hit_e) begin
      wctr = CTR_BITS'(ctr_next(CTR_MAX_W'(e_ctr), bus.taken_E, CTR_BITS));
    end
  end

  assign bus.mispredict_E = bus.update_en_E &&
                            ((bus.taken_E != bus.pred_taken_E) ||
                             (bus.taken_E && (bus.target_E != bus.pred_target_E)));
  assign bus.recover_PC_E = bus.taken_E ? bus.target_E : bus.PC_E + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_q <= '0;
      misp_q   <= '0;
    end else begin
      if (bus.update_en_E && (branch_q != '1)) branch_q <= branch_q + PERF_W'(1);
      if (bus.mispredict_E && (misp_q != '1))  misp_q   <= misp_q + PERF_W'(1);
    end
  end

  assign bus.branch_count     = branch_q;
  assign bus.mispredict_count = misp_q;
  assign unused_bits          = ^{bus.PC_F[1:0], bus.PC_E[1:0], f_ctr};
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks against a table-level reference model
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(32)) bus ();

  branch_predictor #(.WIDTH(32), .ENTRIES(64), .CTR_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  longint      m_br, m_mp;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[7:2]] && (m_tag[pc[7:2]] == pc[31:8]);
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    tk = model_hit(pc) && (m_ctr[pc[7:2]] >= 2);
    tg = tk ? m_tgt[pc[7:2]] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    int i;
    i = int'(pc[7:2]);
    if (model_hit(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tg;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:8];
      m_tgt[i]   = tg;
      m_ctr[i]   = 2;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] pcf, input logic en, input logic [31:0] pce,
                      input logic tk, input logic [31:0] tge, input logic ptk,
                      input logic [31:0] ptg, input logic r);
    logic        e_tk;
    logic [31:0] e_tg;
    logic        e_mp;
    @(negedge clk);
    rst               = r;
    bus.PC_F          = pcf;
    bus.update_en_E   = en;
    bus.PC_E          = pce;
    bus.taken_E       = tk;
    bus.target_E      = tge;
    bus.pred_taken_E  = ptk;
    bus.pred_target_E = ptg;
    #1;
    model_lookup(pcf, e_tk, e_tg);
    e_mp = en && ((tk != ptk) || (tk && (tge != ptg)));
    chk("pred_taken_F", 32'(bus.pred_taken_F), 32'(e_tk));
    chk("pred_target_F", bus.pred_target_F, e_tg);
    chk("mispredict_E", 32'(bus.mispredict_E), 32'(e_mp));
    chk("recover_PC_E", bus.recover_PC_E, tk ? tge : pce + 32'd4);
    chk("branch_count", bus.branch_count, 32'(m_br));
    chk("mispredict_count", bus.mispredict_count, 32'(m_mp));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (en) begin
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (e_mp && (m_mp < 64'hFFFF_FFFF)) m_mp++;
      model_update(pce, tk, tge);
    end
  endtask

  task automatic peek(input logic [31:0] pcf);
    @(negedge clk);
    rst             = 1'b0;
    bus.update_en_E = 1'b0;
    bus.PC_F        = pcf;
    #1;
  endtask

  initial begin
    logic [31:0] pce, tge, ptg;
    logic        tk, ptk, en, r;

    rst = 1'b1;
    bus.PC_F = 32'h100; bus.update_en_E = 1'b0; bus.PC_E = '0; bus.taken_E = 1'b0;
    bus.target_E = '0; bus.pred_taken_E = 1'b0; bus.pred_target_E = '0;
    repeat (2) @(posedge clk);
    model_reset();

    peek(32'h100);
    chk("reset_pred_taken", 32'(bus.pred_taken_F), 32'd0);
    chk("reset_pred_target", bus.pred_target_F, 32'h104);
    chk("reset_branch_count", bus.branch_count, 32'd0);
    chk("reset_misp_count", bus.mispredict_count, 32'd0);

    step(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    peek(32'h100);
    chk("alloc_taken", 32'(bus.pred_taken_F), 32'd1);
    chk("alloc_target", bus.pred_target_F, 32'h80);
    chk("alloc_misp_count", bus.mispredict_count, 32'd1);

    repeat (3) step(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, 0);
    peek(32'h100);
    chk("ctr2_taken", 32'(bus.pred_taken_F), 32'd1);
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, 0);
    peek(32'h100);
    chk("ctr1_not_taken", 32'(bus.pred_taken_F), 32'd0);

    step(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    peek(32'h200);
    chk("alias_miss", 32'(bus.pred_taken_F), 32'd0);
    chk("alias_target", bus.pred_target_F, 32'h204);
    step(32'h200, 1, 32'h200, 0, 32'h0, 0, 32'h204, 0);
    peek(32'h100);
    chk("alias_keep_taken", 32'(bus.pred_taken_F), 32'd1);
    chk("alias_keep_target", bus.pred_target_F, 32'h80);

    step(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
    step(32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80, 0);

    step(32'h300, 1, 32'h300, 1, 32'h40, 0, 32'h304, 1);
    peek(32'h300);
    chk("rst_beats_update", 32'(bus.pred_taken_F), 32'd0);
    chk("rst_branch_count", bus.branch_count, 32'd0);

    for (int n = 0; n < 400; n++) begin
      pce = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      tk  = 1'($urandom_range(0, 1));
      tge = 32'($urandom_range(0, 15)) << 4;
      en  = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 1) != 0) begin
        model_lookup(pce, ptk, ptg);
      end else begin
        ptk = 1'($urandom_range(0, 1));
        ptg = 32'($urandom_range(0, 15)) << 4;
      end
      step((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2),
           en, pce, tk, tge, ptk, ptg, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
